// File: rtl/rotor_pkg.sv
// Shared types for the rotary-encoder event scheduler: event codes and scheduler states.
package rotor_pkg;

    typedef enum logic [1:0] {
        EV_NONE   = 2'b00,
        EV_LEFT   = 2'b01,
        EV_RIGHT  = 2'b10,
        EV_CENTER = 2'b11
    } ev_code_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_HOLD    = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rotor_tick_sched_if.sv
// Tick inputs, flag control and event handshake between encoder front end and menu controller.
interface rotor_tick_sched_if #(
    parameter int unsigned DEPTH = 4
);
    import rotor_pkg::*;

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          left;
    logic          right;
    logic          center;
    logic          clr_flags;
    logic          ev_ready;
    logic          ev_valid;
    ev_code_t      ev_code;
    logic [LW-1:0] level;
    logic          overflow;
    logic          glitch;

    modport master (
        output left, right, center, clr_flags, ev_ready,
        input  ev_valid, ev_code, level, overflow, glitch
    );

    modport slave (
        input  left, right, center, clr_flags, ev_ready,
        output ev_valid, ev_code, level, overflow, glitch
    );

endinterface

// File: rtl/rotor_ev_fifo.sv
// DEPTH x 2-bit register queue; flush beats push, push beats pop. Exposes next-cycle head/level
// so the scheduler can register its outputs with single-cycle latency.
module rotor_ev_fifo
    import rotor_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  ev_code_t               wdata,
    output logic                   full_c,
    output ev_code_t               head_nxt_c,
    output logic [$clog2(DEPTH):0] level_nxt_c,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    ev_code_t          mem_q [DEPTH];
    ev_code_t          mem_d [DEPTH];
    logic [PW-1:0]     rd_q, rd_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push;
    logic              do_pop;

    // Next-state queue update; a full queue still accepts a push when the head leaves the same cycle.
    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        level_d = level_q;
        do_push = 1'b0;
        do_pop  = 1'b0;
        full_c  = (level_q == LW'(DEPTH));

        if (flush) begin
            rd_d    = '0;
            wr_d    = push ? PW'(1) : '0;
            level_d = push ? LW'(1) : '0;
            if (push) begin
                mem_d[0] = wdata;
            end
        end else begin
            do_push = push && (!full_c || pop);
            do_pop  = pop && (level_q != '0);
            if (do_push) begin
                mem_d[wr_q] = wdata;
                wr_d        = wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end

        head_nxt_c  = mem_d[rd_d];
        level_nxt_c = level_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: EV_NONE};
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/rotor_tick_sched.sv
// Rotary tick scheduler: arbitrates ticks into a queue, keeps sticky flags, presents events.
// Optional rate limiting via ROTOR_SCHED_HOLDOFF_EN (HOLD state + holdoff counter).
module rotor_tick_sched
    import rotor_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned HOLDOFF = 8
) (
    input  logic               clk,
    input  logic               rst,
    rotor_tick_sched_if.slave  bus
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    sched_state_t  state_q, state_d;
    logic          ev_valid_q, ev_valid_d;
    ev_code_t      ev_code_q, ev_code_d;
    logic          overflow_q, overflow_d;
    logic          glitch_q, glitch_d;

    logic          single_c;
    logic          push_c;
    logic          pop_c;
    logic          ov_set_c;
    logic          gl_set_c;
    ev_code_t      wdata_c;
    logic          full_c;
    ev_code_t      head_nxt_c;
    logic [LW-1:0] level_nxt_c;

`ifdef ROTOR_SCHED_HOLDOFF_EN
    localparam int unsigned CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_holdoff_c;
    assign unused_holdoff_c = (HOLDOFF == 32'd0);
`endif

    // Tick arbitration: center overrides everything, left+right together is a glitch.
    always_comb begin
        single_c = (bus.left ^ bus.right) && !bus.center;
        gl_set_c = bus.left && bus.right && !bus.center;
        push_c   = bus.center || single_c;
        pop_c    = ev_valid_q && bus.ev_ready;
        ov_set_c = single_c && full_c && !pop_c;
        if (bus.center) begin
            wdata_c = EV_CENTER;
        end else if (bus.left) begin
            wdata_c = EV_LEFT;
        end else begin
            wdata_c = EV_RIGHT;
        end
        overflow_d = ov_set_c || (overflow_q && !bus.clr_flags);
        glitch_d   = gl_set_c || (glitch_q && !bus.clr_flags);
    end

    rotor_ev_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push_c),
        .pop         (pop_c),
        .flush       (bus.center),
        .wdata       (wdata_c),
        .full_c      (full_c),
        .head_nxt_c  (head_nxt_c),
        .level_nxt_c (level_nxt_c),
        .level       (bus.level)
    );

    // Scheduler FSM; outputs follow the next state so they can be registered.
    always_comb begin
        state_d    = state_q;
        ev_valid_d = 1'b0;
        ev_code_d  = EV_NONE;
`ifdef ROTOR_SCHED_HOLDOFF_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (level_nxt_c != '0) begin
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (level_nxt_c == '0) begin
                    state_d = S_IDLE;
`ifdef ROTOR_SCHED_HOLDOFF_EN
                end else if (pop_c && !bus.center) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(HOLDOFF - 1);
`endif
                end
            end
`ifdef ROTOR_SCHED_HOLDOFF_EN
            S_HOLD: begin
                if (level_nxt_c == '0) begin
                    state_d = S_IDLE;
                end else if (bus.center || (cnt_q == '0)) begin
                    state_d = S_PRESENT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_PRESENT) begin
            ev_valid_d = 1'b1;
            ev_code_d  = head_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ev_valid_q <= 1'b0;
            ev_code_q  <= EV_NONE;
            overflow_q <= 1'b0;
            glitch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            overflow_q <= overflow_d;
            glitch_q   <= glitch_d;
        end
    end

`ifdef ROTOR_SCHED_HOLDOFF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.ev_valid = ev_valid_q;
    assign bus.ev_code  = ev_code_q;
    assign bus.overflow = overflow_q;
    assign bus.glitch   = glitch_q;

endmodule

// File: tb/tb_rotor_tick_sched.sv
// Directed bench for rotor_tick_sched (DEPTH=4, HOLDOFF=8); holdoff checks when ROTOR_SCHED_HOLDOFF_EN is defined.
module tb_rotor_tick_sched;
    import rotor_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned HOLDOFF = 8;

    typedef struct {
        string      name;
        logic [5:0] in;     // {rst, left, right, center, clr_flags, ev_ready}
        logic       valid;
        logic [1:0] code;
        logic [2:0] level;
        logic       ov;
        logic       gl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rotor_tick_sched_if #(.DEPTH(DEPTH)) bus ();

    rotor_tick_sched #(
        .DEPTH   (DEPTH),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic [5:0] in, input logic v,
                                input logic [1:0] c, input logic [2:0] lv,
                                input logic ov, input logic gl);
        vec_t r;
        r.name = n; r.in = in; r.valid = v; r.code = c; r.level = lv; r.ov = ov; r.gl = gl;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {rst, bus.left, bus.right, bus.center, bus.clr_flags, bus.ev_ready} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string n, input logic v, input logic [1:0] c,
                             input logic [2:0] lv, input logic ov, input logic gl);
        check({n, ".valid"},    8'(bus.ev_valid), 8'(v));
        check({n, ".code"},     8'(bus.ev_code),  8'(c));
        check({n, ".level"},    8'(bus.level),    8'(lv));
        check({n, ".overflow"}, 8'(bus.overflow), 8'(ov));
        check({n, ".glitch"},   8'(bus.glitch),   8'(gl));
    endtask

    task automatic do_reset();
        drive(6'b100000);
        drive(6'b000000);
    endtask

`ifndef ROTOR_SCHED_HOLDOFF_EN
    vec_t vecs[$];
    logic [1:0] seq_codes [4];
`endif

    initial begin
        {rst, bus.left, bus.right, bus.center, bus.clr_flags, bus.ev_ready} = 6'b100000;
        do_reset();
        check_all("reset", 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);

`ifndef ROTOR_SCHED_HOLDOFF_EN
        vecs.push_back(mk("lat_left",   6'b010001, 1, 2'b01, 3'd1, 0, 0));
        vecs.push_back(mk("lat_pop",    6'b000001, 0, 2'b00, 3'd0, 0, 0));
        vecs.push_back(mk("fill_r1",    6'b001000, 1, 2'b10, 3'd1, 0, 0));
        vecs.push_back(mk("fill_r2",    6'b001000, 1, 2'b10, 3'd2, 0, 0));
        vecs.push_back(mk("fill_r3",    6'b001000, 1, 2'b10, 3'd3, 0, 0));
        vecs.push_back(mk("fill_r4",    6'b001000, 1, 2'b10, 3'd4, 0, 0));
        vecs.push_back(mk("overflow",   6'b001000, 1, 2'b10, 3'd4, 1, 0));
        vecs.push_back(mk("drain1",     6'b000001, 1, 2'b10, 3'd3, 1, 0));
        vecs.push_back(mk("drain2",     6'b000001, 1, 2'b10, 3'd2, 1, 0));
        vecs.push_back(mk("drain3",     6'b000001, 1, 2'b10, 3'd1, 1, 0));
        vecs.push_back(mk("drain4",     6'b000001, 0, 2'b00, 3'd0, 1, 0));
        vecs.push_back(mk("clr_ov",     6'b000010, 0, 2'b00, 3'd0, 0, 0));
        vecs.push_back(mk("glitch",     6'b011000, 0, 2'b00, 3'd0, 0, 1));
        vecs.push_back(mk("clr_gl",     6'b000010, 0, 2'b00, 3'd0, 0, 0));
        vecs.push_back(mk("gl_vs_clr",  6'b011010, 0, 2'b00, 3'd0, 0, 1));
        vecs.push_back(mk("clr_gl2",    6'b000010, 0, 2'b00, 3'd0, 0, 0));
        vecs.push_back(mk("q_l1",       6'b010000, 1, 2'b01, 3'd1, 0, 0));
        vecs.push_back(mk("q_l2",       6'b010000, 1, 2'b01, 3'd2, 0, 0));
        vecs.push_back(mk("q_r3",       6'b001000, 1, 2'b01, 3'd3, 0, 0));
        vecs.push_back(mk("flush",      6'b000100, 1, 2'b11, 3'd1, 0, 0));
        vecs.push_back(mk("q_l_after",  6'b010000, 1, 2'b11, 3'd2, 0, 0));
        vecs.push_back(mk("flush_pop",  6'b000101, 1, 2'b11, 3'd1, 0, 0));
        vecs.push_back(mk("pop_c",      6'b000001, 0, 2'b00, 3'd0, 0, 0));
        vecs.push_back(mk("f_r",        6'b001000, 1, 2'b10, 3'd1, 0, 0));
        vecs.push_back(mk("f_l2",       6'b010000, 1, 2'b10, 3'd2, 0, 0));
        vecs.push_back(mk("f_l3",       6'b010000, 1, 2'b10, 3'd3, 0, 0));
        vecs.push_back(mk("f_l4",       6'b010000, 1, 2'b10, 3'd4, 0, 0));
        vecs.push_back(mk("full_pp",    6'b010001, 1, 2'b01, 3'd4, 0, 0));
        vecs.push_back(mk("d_3",        6'b000001, 1, 2'b01, 3'd3, 0, 0));
        vecs.push_back(mk("d_2",        6'b000001, 1, 2'b01, 3'd2, 0, 0));
        vecs.push_back(mk("d_1",        6'b000001, 1, 2'b01, 3'd1, 0, 0));
        vecs.push_back(mk("d_0",        6'b000001, 0, 2'b00, 3'd0, 0, 0));
        vecs.push_back(mk("pre_rst_r",  6'b001000, 1, 2'b10, 3'd1, 0, 0));
        vecs.push_back(mk("pre_rst_g",  6'b011000, 1, 2'b10, 3'd1, 0, 1));
        vecs.push_back(mk("rst_tick",   6'b110000, 0, 2'b00, 3'd0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            check_all($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].valid, vecs[i].code,
                      vecs[i].level, vecs[i].ov, vecs[i].gl);
        end

        // Back-to-back presentation: alternating ticks with the consumer always ready.
        do_reset();
        seq_codes[0] = 2'b01; seq_codes[1] = 2'b10; seq_codes[2] = 2'b01; seq_codes[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            drive((i % 2 == 0) ? 6'b010001 : 6'b001001);
            check($sformatf("b2b[%0d].valid", i), 8'(bus.ev_valid), 8'd1);
            check($sformatf("b2b[%0d].code", i),  8'(bus.ev_code),  8'(seq_codes[i]));
            check($sformatf("b2b[%0d].level", i), 8'(bus.level),    8'd1);
        end
        drive(6'b000001);
        check("b2b_end.valid", 8'(bus.ev_valid), 8'd0);
        check("b2b_end.level", 8'(bus.level),    8'd0);
`else
        // Three left ticks with ready high: events in cycles 1, 10 and 19 only.
        drive(6'b010001);
        check("ho[1].valid", 8'(bus.ev_valid), 8'd1);
        check("ho[1].code",  8'(bus.ev_code),  8'd1);
        drive(6'b010001);
        check("ho[2].valid", 8'(bus.ev_valid), 8'd0);
        drive(6'b010001);
        check("ho[3].valid", 8'(bus.ev_valid), 8'd0);
        check("ho[3].level", 8'(bus.level),    8'd2);
        for (int cyc = 4; cyc <= 28; cyc++) begin
            drive(6'b000001);
            check($sformatf("ho[%0d].valid", cyc), 8'(bus.ev_valid),
                  8'((cyc == 10) || (cyc == 19)));
            if ((cyc == 10) || (cyc == 19)) begin
                check($sformatf("ho[%0d].code", cyc), 8'(bus.ev_code), 8'd1);
            end
        end
        check("ho_end.level", 8'(bus.level), 8'd0);

        // Center tick while holding off jumps straight to presentation.
        do_reset();
        drive(6'b010001);
        drive(6'b010001);
        check("hc_hold.valid", 8'(bus.ev_valid), 8'd0);
        drive(6'b000100);
        check_all("hc_center", 1'b1, 2'b11, 3'd1, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotor_tick_sched.md
# rotor_tick_sched

Event scheduler between the rotary-encoder front end (quadrature decoder left/right ticks, debounced center tick) and the LED/menu controller. Captures one-cycle tick pulses into a small FIFO, resolves simultaneous and conflicting ticks, and presents events one at a time to the consumer over a valid/ready handshake. No tick is lost while the consumer is busy unless the queue is full, and that loss is flagged.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- HOLDOFF, 8: minimum idle cycles between presented events; used only with the holdoff feature; ≥1.
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset; one clock, synchronous, active-high.
- left  in  1  one-cycle counter-clockwise tick.
- right  in  1  one-cycle clockwise tick.
- center  in  1  one-cycle debounced push tick.
- clr_flags  in  1  clears overflow and glitch flags.
- ev_ready  in  1  consumer accepts the current event.
- ev_valid  out  1  event presented.
- ev_code  out  2  00 none, 01 left, 10 right, 11 center.
- level  out  $clog2(DEPTH)+1  queued entries, including the one presented.
- overflow  out  1  sticky: a tick was dropped because the queue was full.
- glitch  out  1  sticky: left and right arrived in the same cycle.

## Operation
- Enqueue, left only or right only: write the code at the tail if not full. If full, drop the tick and set overflow.
- Full with pop in the same cycle (ev_valid & ev_ready): the slot counts as free and the write succeeds.
- Left & right together, center low: drop both and set glitch; the queue is unchanged.
- Center high, regardless of left/right: flush the queue and write a single center entry. A pop in the same cycle is absorbed by the flush, so level is 1 next cycle.
- clr_flags clears overflow and glitch. An event setting a flag in the same cycle wins, and the flag stays 1.
- State machine:
  - IDLE: ev_valid=0, ev_code=00.
  - PRESENT: ev_valid=1, ev_code=head.
  - HOLD: ev_valid=0, ev_code=00, holdoff counter running.
- Transitions:
  - IDLE→PRESENT when level becomes nonzero.
  - PRESENT, handshake, queue empty after pop → IDLE.
  - PRESENT, handshake, queue nonempty → PRESENT with the next head (no holdoff), or HOLD (holdoff).
  - HOLD→PRESENT after HOLDOFF cycles, or immediately next cycle on a center tick.
- ev_code and ev_valid stay stable while ev_valid=1 and ev_ready=0, except on a center flush, where head becomes 11.
- level never exceeds DEPTH. Pointers wrap modulo DEPTH.

## Timing
- All outputs registered. Reset values: ev_valid=0, ev_code=00, level=0, overflow=0, glitch=0, state IDLE, pointers 0, holdoff counter 0.
- Latency: tick in cycle N with an empty queue gives ev_valid=1 in cycle N+1.
- Throughput without holdoff: one event per cycle with ev_ready held high.
- With holdoff: after an accepted event, ev_valid is low for exactly HOLDOFF cycles before the next event.
- rst in any cycle clears everything at the next edge; ticks in the rst cycle are discarded.

## Configuration
- ROTOR_SCHED_HOLDOFF_EN defined: HOLD state and holdoff counter are built, and events are rate-limited as above.
- Undefined: HOLD is unreachable and removed; HOLDOFF is ignored; back-to-back presentation applies.

## Structure
- Shared package rotor_pkg holds:
  - ev_code constants EV_NONE, EV_LEFT, EV_RIGHT, EV_CENTER.
  - scheduler state encoding S_IDLE, S_PRESENT, S_HOLD.
- Sub-module rotor_ev_fifo: DEPTH×2-bit register queue with push, pop, flush, head, level and full. Flush has priority over push, and push over pop.
- Arbitration, flags and the state machine live in rotor_tick_sched.

## Test plan
- Reset, then left in cycle 0 with ev_ready=1 → ev_valid=1, ev_code=01 in cycle 1; ev_valid=0 and level=0 in cycle 2.
- ev_ready=0, right ×5 with DEPTH=4 → level=4 and overflow=1; then ev_ready=1 drains 10,10,10,10 on consecutive cycles.
- left & right in the same cycle → glitch=1, level unchanged; clr_flags → glitch=0 next cycle.
- Queue holding left,left,right, then center → next cycle level=1, ev_code=11, ev_valid=1.
- Full queue with a pop and a left push in the same cycle → level stays 4, no overflow.
- ROTOR_SCHED_HOLDOFF_EN with HOLDOFF=8: three left ticks, ev_ready=1 → events 8 idle cycles apart. A center tick during HOLD → PRESENT with 11 next cycle.
